stack_controller: RTL
=====================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameter DEPTH, default 16: stack capacity in entries; legal range 2..256.
REQ-002 Parameter SPW, default $clog2(DEPTH+1): width of sp_count; derived from DEPTH, never overridden.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port inst, input, 4: opcode field of IR, sampled in DECODE.
REQ-006 Port mem_ready, input, 1: stack memory accepts the current push/pop this cycle.
REQ-007 Port resume, input, 1: leave HALT.
REQ-008 Ports ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable, output, 1 each: datapath strobes.
REQ-009 Port ALUop, output, 2: ALU operation (00 add, 01 sub, 10 and, 11 not).
REQ-010 Port sp_count, output, SPW: current stack occupancy.
REQ-011 Ports busy, halted, fault, output, 1 each; fault_code, output, 2: status outputs.

Function
REQ-012 States: FETCH, DECODE, EXEC, INCPC, HALT, FAULT, plus a 3-bit step counter; all outputs are combinational from state, step, inst and mem_ready.
REQ-013 Any strobe not listed for the current state/step SHALL be 0; ALUop SHALL be 00 unless listed; no output is ever latched.
REQ-014 FETCH: ld_IR=1; next state DECODE; step cleared to 0.
REQ-015 DECODE, opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 NOT, 0100 PUSH, 0101 POP, 0110 JUMP, 0111 JZ, 1000 HALT; 1001-1111 -> FAULT, code 11.
REQ-016 DECODE, stack checks before EXEC: ADD/SUB/AND need sp_count>=2, NOT/POP need >=1, else FAULT code 01 (underflow); PUSH needs sp_count<DEPTH, else FAULT code 10 (overflow).
REQ-017 DECODE HALT -> HALT state; other legal opcodes -> EXEC at step 0.
REQ-018 ADD/SUB/AND steps, with ALUop = 00/01/10 respectively in steps 3-4: 0 ldA; 1 pop; 2 ldB; 3 pop + ALUop; 4 push + MEMorALU + ALUop -> INCPC.
REQ-019 NOT steps: 0 ldA; 1 pop + ALUop=11; 2 push + MEMorALU + ALUop=11 -> INCPC.
REQ-020 PUSH steps: 0 PCorIR; 1 push -> INCPC.
REQ-021 POP steps: 0 ldA; 1 pop + write_enable -> INCPC.
REQ-022 JUMP: single step, J + PCwrite -> FETCH. JZ: single step, JZ + PCwrite -> FETCH. No INCPC for either.
REQ-023 INCPC steps: 0 PCup; 1 PCwrite -> FETCH.
REQ-024 Handshake: a step asserting push or pop SHALL hold, with identical outputs, while mem_ready=0; it advances only in a cycle with mem_ready=1.
REQ-025 All other steps advance unconditionally each cycle.
REQ-026 sp_count SHALL +1 on each push cycle with mem_ready=1 and -1 on each pop cycle with mem_ready=1; it never wraps, since DECODE checks guarantee range.
REQ-027 Net sp_count per instruction: ADD/SUB/AND -1, NOT 0, PUSH +1, POP -1.
REQ-028 HALT: halted=1, all strobes 0; resume=1 -> INCPC; resume during any other state is ignored.
REQ-029 FAULT: fault=1, fault_code held, all strobes 0; sticky until reset; fault_code is 00 whenever fault=0.
REQ-030 busy SHALL be 1 in every state except HALT and FAULT.

Reset
REQ-031 rst low SHALL immediately, without waiting for a clock edge, force state FETCH, step 0, sp_count 0, fault_code 00, and all strobes, ALUop, halted and fault to 0, including mid-instruction or while waiting on mem_ready.
REQ-032 On the first rising clk edge after rst goes high, the controller sits in FETCH with ld_IR=1 and busy=1.

Verification
REQ-033 Reset release, then PUSH, PUSH, ADD with mem_ready=1 -> ADD strobes ldA, pop, ldB, pop+ALUop=00, push+MEMorALU on consecutive cycles; sp_count goes 0,1,2,1.
REQ-034 ADD issued with sp_count=1 -> FAULT, fault_code=01, busy=0, no push/pop ever pulsed; only rst clears it.
REQ-035 DEPTH=2, three PUSHes -> third DECODE enters FAULT with code 10; sp_count stays 2.
REQ-036 PUSH with mem_ready=0 for 3 cycles at step 1 -> push held 4 cycles total; sp_count increments exactly once.
REQ-037 inst=1010 -> FAULT code 11; separately, HALT then resume=1 -> halted=0, INCPC PCup then PCwrite, then FETCH.
REQ-038 JZ -> one cycle with JZ=1 and PCwrite=1, PCup never asserted, then FETCH; rst pulled low at ADD step 2 -> outputs 0 at once, sp_count=0.

Source files
------------

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - micro-sequencer for a stack-machine datapath with occupancy tracking
// Outputs are decoded from state, step and opcode; only state, step, sp_count and fault code are stored.
module stack_controller #(
  parameter int DEPTH = 16,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     inst,
  input  logic           mem_ready,
  input  logic           resume,
  output logic           ld_IR,
  output logic           PCorIR,
  output logic           push,
  output logic           pop,
  output logic           MEMorALU,
  output logic           ldA,
  output logic           ldB,
  output logic           PCup,
  output logic           PCwrite,
  output logic           J,
  output logic           JZ,
  output logic           write_enable,
  output logic [1:0]     ALUop,
  output logic [SPW-1:0] sp_count,
  output logic           busy,
  output logic           halted,
  output logic           fault,
  output logic [1:0]     fault_code
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_INCPC, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_PUSH = 4'b0100;
  localparam logic [3:0] OP_POP  = 4'b0101;
  localparam logic [3:0] OP_JUMP = 4'b0110;
  localparam logic [3:0] OP_JZ   = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1000;

  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  state_t         state, state_nxt;
  logic [2:0]     step, step_nxt, last_step;
  logic [1:0]     code_q, code_nxt;
  logic [SPW-1:0] sp_q, sp_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_FETCH;
      step   <= 3'd0;
      code_q <= 2'b00;
      sp_q   <= '0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      code_q <= code_nxt;
      sp_q   <= sp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    code_nxt  = code_q;
    sp_nxt    = sp_q;
    case (inst)
      OP_ADD, OP_SUB, OP_AND: last_step = 3'd4;
      OP_NOT:                 last_step = 3'd2;
      OP_PUSH, OP_POP:        last_step = 3'd1;
      default:                last_step = 3'd0;
    endcase
    case (state)
      S_FETCH: begin
        state_nxt = S_DECODE;
        step_nxt  = 3'd0;
      end
      S_DECODE: begin
        step_nxt  = 3'd0;
        state_nxt = S_EXEC;
        case (inst)
          OP_ADD, OP_SUB, OP_AND:
            if (sp_q < SP_TWO) begin state_nxt = S_FAULT; code_nxt = 2'b01; end
          OP_NOT, OP_POP:
            if (sp_q < SP_ONE) begin state_nxt = S_FAULT; code_nxt = 2'b01; end
          OP_PUSH:
            if (sp_q >= SP_FULL) begin state_nxt = S_FAULT; code_nxt = 2'b10; end
          OP_JUMP, OP_JZ: ;
          OP_HALT: state_nxt = S_HALT;
          default: begin state_nxt = S_FAULT; code_nxt = 2'b11; end
        endcase
      end
      S_EXEC: begin
        // Memory steps stall in place until the stack memory takes the access
        if (!(push || pop) || mem_ready) begin
          if (push) sp_nxt = sp_q + SP_ONE;
          if (pop)  sp_nxt = sp_q - SP_ONE;
          if (step == last_step) begin
            step_nxt  = 3'd0;
            state_nxt = (inst == OP_JUMP || inst == OP_JZ) ? S_FETCH : S_INCPC;
          end else begin
            step_nxt = step + 3'd1;
          end
        end
      end
      S_INCPC: begin
        if (step == 3'd0) begin
          step_nxt = 3'd1;
        end else begin
          step_nxt  = 3'd0;
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_nxt = S_INCPC;
          step_nxt  = 3'd0;
        end
      end
      S_FAULT: ;
      default: begin
        state_nxt = S_FETCH;
        step_nxt  = 3'd0;
      end
    endcase
  end

  always_comb begin
    ld_IR = 1'b0; PCorIR = 1'b0; push = 1'b0; pop = 1'b0; MEMorALU = 1'b0;
    ldA = 1'b0; ldB = 1'b0; PCup = 1'b0; PCwrite = 1'b0; J = 1'b0; JZ = 1'b0;
    write_enable = 1'b0; ALUop = 2'b00; halted = 1'b0; fault = 1'b0; fault_code = 2'b00;
    busy = (state != S_HALT) && (state != S_FAULT);
    sp_count = sp_q;
    // Reset gates every strobe combinationally so it takes effect without a clock
    if (rst) begin
      case (state)
        S_FETCH: ld_IR = 1'b1;
        S_EXEC: begin
          case (inst)
            OP_ADD, OP_SUB, OP_AND: begin
              case (step)
                3'd0: ldA = 1'b1;
                3'd1: pop = 1'b1;
                3'd2: ldB = 1'b1;
                3'd3: begin pop = 1'b1; ALUop = inst[1:0]; end
                3'd4: begin push = 1'b1; MEMorALU = 1'b1; ALUop = inst[1:0]; end
                default: ;
              endcase
            end
            OP_NOT: begin
              case (step)
                3'd0: ldA = 1'b1;
                3'd1: begin pop = 1'b1; ALUop = 2'b11; end
                3'd2: begin push = 1'b1; MEMorALU = 1'b1; ALUop = 2'b11; end
                default: ;
              endcase
            end
            OP_PUSH: begin
              if (step == 3'd0) PCorIR = 1'b1;
              else              push = 1'b1;
            end
            OP_POP: begin
              if (step == 3'd0) ldA = 1'b1;
              else begin pop = 1'b1; write_enable = 1'b1; end
            end
            OP_JUMP: begin J = 1'b1; PCwrite = 1'b1; end
            OP_JZ:   begin JZ = 1'b1; PCwrite = 1'b1; end
            default: ;
          endcase
        end
        S_INCPC: begin
          if (step == 3'd0) PCup = 1'b1;
          else              PCwrite = 1'b1;
        end
        S_HALT: halted = 1'b1;
        S_FAULT: begin
          fault      = 1'b1;
          fault_code = code_q;
        end
        default: ;
      endcase
    end
  end

endmodule
